ef_adc_ahbl_fifo_reader: RTL

//  AHB-Lite initiator that drains the ADC controller's sample FIFO over the bus. On the
//  ADC interrupt it reads FIFOLEVEL, reads DATA that many times, streams each 10-bit

---
 rtl/ef_adc_ahbl_fifo_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ef_adc_ahbl_fifo_reader.sv
// AHB-Lite initiator that drains the ADC sample FIFO on interrupt: reads FIFOLEVEL,
// reads DATA that many times, streams each sample out valid/ready, then clears ICR.
module ef_adc_ahbl_fifo_reader #(
    parameter logic [31:0] BASE      = 32'h4000_0000,
    parameter int          LVL_W     = 5,
    parameter int          MAX_BURST = 16,
    parameter logic [31:0] ICR_VAL   = 32'h0000_000F
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        en,
    input  logic        irq,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP,
    output logic [9:0]  s_data,
    output logic        s_valid,
    input  logic        s_ready,
    output logic        busy,
    output logic        err
);

    localparam int          CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [31:0] ADDR_DATA = BASE + 32'h18;
    localparam logic [31:0] ADDR_LVL  = BASE + 32'h1C;
    localparam logic [31:0] ADDR_ICR  = BASE + 32'hF00;
    localparam logic [1:0]  HT_IDLE   = 2'b00;
    localparam logic [1:0]  HT_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        IDLE, LVL_A, LVL_D, DAT_A, DAT_D, HOLD, ICR_A, ICR_D
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               unused_hrdata;

    // Only the low bits of the read data carry level or sample information.
    assign unused_hrdata = ^HRDATA;
    assign HSIZE         = 3'b010;

    function automatic logic [CNT_W-1:0] clamp_level(input logic [LVL_W-1:0] level);
        if (int'(level) > MAX_BURST)
            return CNT_W'(MAX_BURST);
        return CNT_W'(level);
    endfunction

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            HADDR   <= '0;
            HTRANS  <= HT_IDLE;
            HWRITE  <= 1'b0;
            HWDATA  <= '0;
            s_data  <= '0;
            s_valid <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && irq) begin
                        state  <= LVL_A;
                        HADDR  <= ADDR_LVL;
                        HTRANS <= HT_NONSEQ;
                        HWRITE <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                LVL_A: begin
                    if (HREADY) begin
                        state  <= LVL_D;
                        HTRANS <= HT_IDLE;
                    end
                end
                LVL_D: begin
                    if (HREADY) begin
                        if (HRESP || clamp_level(HRDATA[LVL_W-1:0]) == '0) begin
                            err    <= HRESP;
                            state  <= ICR_A;
                            HADDR  <= ADDR_ICR;
                            HWRITE <= 1'b1;
                            HTRANS <= HT_NONSEQ;
                        end else begin
                            cnt    <= clamp_level(HRDATA[LVL_W-1:0]);
                            state  <= DAT_A;
                            HADDR  <= ADDR_DATA;
                            HTRANS <= HT_NONSEQ;
                        end
                    end
                end
                DAT_A: begin
                    if (HREADY) begin
                        state  <= DAT_D;
                        HTRANS <= HT_IDLE;
                    end
                end
                DAT_D: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            // Errored read: drop the sample and go straight to clearing the interrupt.
                            err    <= 1'b1;
                            state  <= ICR_A;
                            HADDR  <= ADDR_ICR;
                            HWRITE <= 1'b1;
                            HTRANS <= HT_NONSEQ;
                        end else begin
                            s_data  <= HRDATA[9:0];
                            s_valid <= 1'b1;
                            cnt     <= cnt - CNT_W'(1);
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (s_valid && s_ready) begin
                        s_valid <= 1'b0;
                        HTRANS  <= HT_NONSEQ;
                        if (cnt != '0) begin
                            state <= DAT_A;
                            HADDR <= ADDR_DATA;
                        end else begin
                            state  <= ICR_A;
                            HADDR  <= ADDR_ICR;
                            HWRITE <= 1'b1;
                        end
                    end
                end
                ICR_A: begin
                    if (HREADY) begin
                        state  <= ICR_D;
                        HTRANS <= HT_IDLE;
                        HWDATA <= ICR_VAL;
                    end
                end
                ICR_D: begin
                    if (HREADY) begin
                        err    <= HRESP;
                        state  <= IDLE;
                        HWRITE <= 1'b0;
                        HWDATA <= '0;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    HTRANS <= HT_IDLE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
